// File: rtl/systolic_output_deskew.sv
// Systolic array output deskew: per-lane delay lines realign staggered column outputs into one registered vector per row.
// Optional misalignment checker enabled by defining DESKEW_ERR_CHECK_EN.
module systolic_output_deskew #(
  parameter int NumLanes   = 4,
  parameter int DataWidth  = 8,
  parameter int CountWidth = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic [NumLanes*DataWidth-1:0] data_i,
  input  logic [NumLanes-1:0]           valid_i,
  output logic [NumLanes*DataWidth-1:0] data_o,
  output logic                          valid_o,
  output logic [CountWidth-1:0]         count_o,
  output logic                          err_o
);

  logic [NumLanes*DataWidth-1:0] dly_data;
  logic [NumLanes-1:0]           dly_valid;
  logic                          aligned_valid;

  // Lane i lags lane 0 by i cycles, so it needs NumLanes-1-i stages to line up with the last lane.
  for (genvar gi = 0; gi < NumLanes; gi++) begin : g_lane
    localparam int Depth = NumLanes - 1 - gi;

    if (Depth == 0) begin : g_pass
      assign dly_data[gi*DataWidth +: DataWidth] = data_i[gi*DataWidth +: DataWidth];
      assign dly_valid[gi]                       = valid_i[gi];
    end else begin : g_pipe
      logic [DataWidth-1:0] pipe_data [Depth];
      logic [Depth-1:0]     pipe_valid;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int s = 0; s < Depth; s++) begin
            pipe_data[s]  <= '0;
            pipe_valid[s] <= 1'b0;
          end
        end else if (clear_i) begin
          for (int s = 0; s < Depth; s++) begin
            pipe_data[s]  <= '0;
            pipe_valid[s] <= 1'b0;
          end
        end else begin
          pipe_data[0]  <= data_i[gi*DataWidth +: DataWidth];
          pipe_valid[0] <= valid_i[gi];
          for (int s = 1; s < Depth; s++) begin
            pipe_data[s]  <= pipe_data[s-1];
            pipe_valid[s] <= pipe_valid[s-1];
          end
        end
      end

      assign dly_data[gi*DataWidth +: DataWidth] = pipe_data[Depth-1];
      assign dly_valid[gi]                       = pipe_valid[Depth-1];
    end
  end

`ifdef DESKEW_ERR_CHECK_EN
  logic mismatch;

  assign aligned_valid = &dly_valid;
  assign mismatch      = (|dly_valid) & ~(&dly_valid);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (clear_i) begin
      err_o <= 1'b0;
    end else if (mismatch) begin
      err_o <= 1'b1;
    end
  end
`else
  logic unused_valids;

  // Without the checker only lane 0 qualifies the row; the other delayed valids are deliberately dropped.
  assign aligned_valid = dly_valid[0];
  assign unused_valids = ^dly_valid[NumLanes-1:1];
  assign err_o         = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      count_o <= '0;
    end else if (clear_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      count_o <= '0;
    end else begin
      valid_o <= aligned_valid;
      if (aligned_valid) begin
        data_o  <= dly_data;
        count_o <= count_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Directed vector bench for systolic_output_deskew: table of per-cycle inputs with expected outputs, plus reset/misalignment sequences.
module tb_systolic_output_deskew;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [31:0] data_in;
  logic [3:0]  valid_in;
  logic [31:0] data_out, data_out_w;
  logic        valid_out, valid_out_w;
  logic [15:0] count_out;
  logic [1:0]  count_out_w;
  logic        err_out, err_out_w;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  systolic_output_deskew #(.NumLanes(4), .DataWidth(8), .CountWidth(16)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .data_i(data_in), .valid_i(valid_in),
    .data_o(data_out), .valid_o(valid_out), .count_o(count_out), .err_o(err_out)
  );

  systolic_output_deskew #(.NumLanes(4), .DataWidth(8), .CountWidth(2)) dut_w (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .data_i(data_in), .valid_i(valid_in),
    .data_o(data_out_w), .valid_o(valid_out_w), .count_o(count_out_w), .err_o(err_out_w)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  valid;
    logic        clr;
    logic [31:0] exp_data;
    logic        exp_valid;
    logic [15:0] exp_count;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] d, input logic [3:0] v, input logic c);
    data_in  = d;
    valid_in = v;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [31:0] ed, input logic ev,
                         input logic [15:0] ec, input logic ee);
    n_vec++;
    chk({nm, ".data"},  data_out,           ed);
    chk({nm, ".valid"}, {31'd0, valid_out}, {31'd0, ev});
    chk({nm, ".count"}, {16'd0, count_out}, {16'd0, ec});
    chk({nm, ".err"},   {31'd0, err_out},   {31'd0, ee});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            data_i        valid   clr   exp_data      ev    cnt
    tbl[0]  = '{32'h00000010, 4'b0001, 1'b0, 32'h00000000, 1'b0, 16'd0};
    tbl[1]  = '{32'h00001100, 4'b0010, 1'b0, 32'h00000000, 1'b0, 16'd0};
    tbl[2]  = '{32'h00120000, 4'b0100, 1'b0, 32'h00000000, 1'b0, 16'd0};
    tbl[3]  = '{32'h13000000, 4'b1000, 1'b0, 32'h13121110, 1'b1, 16'd1};
    tbl[4]  = '{32'h00000000, 4'b0000, 1'b0, 32'h13121110, 1'b0, 16'd1};
    tbl[5]  = '{32'h00000000, 4'b0000, 1'b0, 32'h13121110, 1'b0, 16'd1};
    // five back-to-back skewed rows, lane value 8'h20+row
    tbl[6]  = '{32'h00000020, 4'b0001, 1'b0, 32'h13121110, 1'b0, 16'd1};
    tbl[7]  = '{32'h00002021, 4'b0011, 1'b0, 32'h13121110, 1'b0, 16'd1};
    tbl[8]  = '{32'h00202122, 4'b0111, 1'b0, 32'h13121110, 1'b0, 16'd1};
    tbl[9]  = '{32'h20212223, 4'b1111, 1'b0, 32'h20202020, 1'b1, 16'd2};
    tbl[10] = '{32'h21222324, 4'b1111, 1'b0, 32'h21212121, 1'b1, 16'd3};
    tbl[11] = '{32'h22232400, 4'b1110, 1'b0, 32'h22222222, 1'b1, 16'd4};
    tbl[12] = '{32'h23240000, 4'b1100, 1'b0, 32'h23232323, 1'b1, 16'd5};
    tbl[13] = '{32'h24000000, 4'b1000, 1'b0, 32'h24242424, 1'b1, 16'd6};
    tbl[14] = '{32'h00000000, 4'b0000, 1'b0, 32'h24242424, 1'b0, 16'd6};
    // flush at lane-2 cycle; remaining row never emerges
    tbl[15] = '{32'h00000030, 4'b0001, 1'b0, 32'h24242424, 1'b0, 16'd6};
    tbl[16] = '{32'h00003100, 4'b0010, 1'b0, 32'h24242424, 1'b0, 16'd6};
    tbl[17] = '{32'h00320000, 4'b0100, 1'b1, 32'h00000000, 1'b0, 16'd0};
    tbl[18] = '{32'h00000000, 4'b0000, 1'b0, 32'h00000000, 1'b0, 16'd0};
    tbl[19] = '{32'h00000000, 4'b0000, 1'b0, 32'h00000000, 1'b0, 16'd0};
    tbl[20] = '{32'h00000040, 4'b0001, 1'b0, 32'h00000000, 1'b0, 16'd0};
    tbl[21] = '{32'h00004100, 4'b0010, 1'b0, 32'h00000000, 1'b0, 16'd0};
    tbl[22] = '{32'h00420000, 4'b0100, 1'b0, 32'h00000000, 1'b0, 16'd0};
    tbl[23] = '{32'h43000000, 4'b1000, 1'b0, 32'h43424140, 1'b1, 16'd1};
    tbl[24] = '{32'h00000000, 4'b0000, 1'b0, 32'h43424140, 1'b0, 16'd1};

    rst = 1'b1; clear = 1'b0; data_in = '0; valid_in = '0;
    #2;
    chk_all("reset", 32'h0, 1'b0, 16'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // wrap instance only sees the clear at entry 17, so its count is the 16-bit count mod 4
    for (int k = 0; k < 25; k++) begin
      cyc(tbl[k].data, tbl[k].valid, tbl[k].clr);
      chk_all($sformatf("vec%0d", k), tbl[k].exp_data, tbl[k].exp_valid, tbl[k].exp_count, 1'b0);
      chk($sformatf("vec%0d.wrap_count", k), {30'd0, count_out_w}, {30'd0, tbl[k].exp_count[1:0]});
    end

    // async reset between edges with a row in flight
    cyc(32'h00000050, 4'b0001, 1'b0);
    cyc(32'h00005100, 4'b0010, 1'b0);
    data_in = '0; valid_in = '0;
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, 1'b0, 16'd0, 1'b0);
    @(posedge clk); #1;
    chk_all("rst_held", 32'h0, 1'b0, 16'd0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc(32'h0, 4'b0000, 1'b0);
      chk_all($sformatf("post_rst%0d", k), 32'h0, 1'b0, 16'd0, 1'b0);
    end

    // row with lane 2 one cycle late
    cyc(32'h00000010, 4'b0001, 1'b0);
    cyc(32'h00001100, 4'b0010, 1'b0);
    cyc(32'h00000000, 4'b0000, 1'b0);
    cyc(32'h13000000, 4'b1000, 1'b0);
`ifdef DESKEW_ERR_CHECK_EN
    n_vec++;
    chk("mis_t4.valid", {31'd0, valid_out}, 32'd0);
    chk("mis_t4.count", {16'd0, count_out}, 32'd0);
    cyc(32'h00120000, 4'b0100, 1'b0);
    chk_all("mis_t5", 32'h0, 1'b0, 16'd0, 1'b1);
    cyc(32'h0, 4'b0000, 1'b0);
    chk_all("mis_sticky", 32'h0, 1'b0, 16'd0, 1'b1);
`else
    chk_all("mis_t4", 32'h13001110, 1'b1, 16'd1, 1'b0);
    cyc(32'h00120000, 4'b0100, 1'b0);
    chk_all("mis_t5", 32'h13001110, 1'b0, 16'd1, 1'b0);
    cyc(32'h0, 4'b0000, 1'b0);
    chk_all("mis_after", 32'h13001110, 1'b0, 16'd1, 1'b0);
`endif
    cyc(32'h0, 4'b0000, 1'b1);
    chk_all("mis_clear", 32'h0, 1'b0, 16'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
